// File: rtl/sdram_rr_arbiter_if.sv
// Avalon-MM bus bundle shared by the two video masters and the SDRAM port.
// Use the master modport on the side that issues commands and the slave modport on the side that answers them.
interface sdram_rr_arbiter_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4
);
  localparam int DW = 8 * DATA_BYTES;

  logic [ADDR_W-1:0]     address;
  logic                  read;
  logic                  write;
  logic [DW-1:0]         writedata;
  logic [DATA_BYTES-1:0] byteenable;
  logic                  waitrequest;
  logic [DW-1:0]         readdata;
  logic                  readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of the SDRAM port, with per-grant quantum and read-ID FIFO.
// Optional per-master acceptance counters (stat_acc0/1) are built when ARB_STATS_EN is defined.
module sdram_rr_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_BYTES  = 4,
  parameter int MAX_PENDING = 8,
  parameter int QUANTUM     = 16
)(
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  sdram_rr_arbiter_if.slave      m0,
  sdram_rr_arbiter_if.slave      m1,
  sdram_rr_arbiter_if.master     s,
  output logic                   arb_err
`ifdef ARB_STATS_EN
  , output logic [31:0]          stat_acc0
  , output logic [31:0]          stat_acc1
`endif
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CW-1:0] QMAX  = CW'(QUANTUM - 1);
  localparam logic [PW:0]   FDEPTH = (PW+1)'(MAX_PENDING);

  typedef enum logic [1:0] {ST_IDLE, ST_G0, ST_G1} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_rr_last, w_rr_nxt;
  logic [CW-1:0]   r_q, w_q_nxt;

  logic [MAX_PENDING-1:0] r_fifo;
  logic [PW-1:0]          r_wp, r_rp;
  logic [PW:0]            r_fcnt;

  logic w_req0, w_req1, w_g0, w_g1, w_gid, w_req_own, w_req_oth;
  logic w_full, w_nempty, w_head, w_rd, w_wr, w_sread, w_acc, w_push, w_pop;
  logic [ADDR_W-1:0]     w_addr;
  logic [DW-1:0]         w_wdata;
  logic [DATA_BYTES-1:0] w_be;
  state_t                w_oth_st;

  assign w_req0    = m0.read | m0.write;
  assign w_req1    = m1.read | m1.write;
  assign w_g0      = (r_state == ST_G0);
  assign w_g1      = (r_state == ST_G1);
  assign w_gid     = w_g1;
  assign w_req_own = w_gid ? w_req1 : w_req0;
  assign w_req_oth = w_gid ? w_req0 : w_req1;
  assign w_oth_st  = w_gid ? ST_G0 : ST_G1;

  assign w_full   = (r_fcnt == FDEPTH);
  assign w_nempty = (r_fcnt != '0);
  assign w_head   = r_fifo[r_rp];

  // Read wins over write when a master illegally asserts both.
  assign w_rd    = (w_g0 & m0.read) | (w_g1 & m1.read);
  assign w_wr    = (w_g0 & m0.write & ~m0.read) | (w_g1 & m1.write & ~m1.read);
  assign w_sread = w_rd & ~w_full;
  assign w_acc   = (w_sread | w_wr) & ~s.waitrequest;
  assign w_push  = w_acc & w_sread;
  assign w_pop   = s.readdatavalid & w_nempty;

  assign w_addr  = w_g1 ? m1.address    : m0.address;
  assign w_wdata = w_g1 ? m1.writedata  : m0.writedata;
  assign w_be    = w_g1 ? m1.byteenable : m0.byteenable;

  assign s.address    = w_addr;
  assign s.writedata  = w_wdata;
  assign s.byteenable = w_be;
  assign s.read       = w_sread;
  assign s.write      = w_wr;

  assign m0.waitrequest   = w_g0 ? (s.waitrequest | (m0.read & w_full)) : 1'b1;
  assign m1.waitrequest   = w_g1 ? (s.waitrequest | (m1.read & w_full)) : 1'b1;
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = w_pop & ~w_head;
  assign m1.readdatavalid = w_pop &  w_head;

  // Switching only happens when the owner drops its request or just had a command accepted,
  // so a presented-but-stalled command keeps its grant.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_last;
    w_q_nxt     = r_q;
    case (r_state)
      ST_IDLE: begin
        w_q_nxt = '0;
        if (w_req0 && w_req1) w_state_nxt = r_rr_last ? ST_G0 : ST_G1;
        else if (w_req0)      w_state_nxt = ST_G0;
        else if (w_req1)      w_state_nxt = ST_G1;
      end
      default: begin
        if (!w_req_own) begin
          w_state_nxt = w_req_oth ? w_oth_st : ST_IDLE;
          w_rr_nxt    = w_gid;
          w_q_nxt     = '0;
        end else if (w_acc) begin
          if (r_q == QMAX && w_req_oth) begin
            w_state_nxt = w_oth_st;
            w_rr_nxt    = w_gid;
            w_q_nxt     = '0;
          end else if (r_q != QMAX) begin
            w_q_nxt = r_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_rr_last <= 1'b1;
      r_q       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_last <= w_rr_nxt;
      r_q       <= w_q_nxt;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_fifo  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_fcnt  <= '0;
      arb_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= w_gid;
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
      if (s.readdatavalid && !w_nempty) arb_err <= 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stat_acc0 <= '0;
      stat_acc1 <= '0;
    end else begin
      if (w_acc && w_g0 && stat_acc0 != 32'hFFFF_FFFF) stat_acc0 <= stat_acc0 + 1'b1;
      if (w_acc && w_g1 && stat_acc1 != 32'hFFFF_FFFF) stat_acc1 <= stat_acc1 + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter: routing, quantum fairness, stall-hold, FIFO-full stall, error flag, reset.
`timescale 1ns/1ps
module tb_sdram_rr_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic arb_err;
`ifdef ARB_STATS_EN
  logic [31:0] stat_acc0, stat_acc1;
`endif

  sdram_rr_arbiter_if m0_if();
  sdram_rr_arbiter_if m1_if();
  sdram_rr_arbiter_if s_if();

  sdram_rr_arbiter dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .m0      (m0_if.slave),
    .m1      (m1_if.slave),
    .s       (s_if.master),
    .arb_err (arb_err)
`ifdef ARB_STATS_EN
    , .stat_acc0 (stat_acc0)
    , .stat_acc1 (stat_acc1)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // SDRAM model: fixed 3-cycle read latency plus a manual readdatavalid injector
  typedef struct { int due; logic [31:0] addr; } pend_t;
  pend_t       pend_q[$];
  logic        model_en = 1'b1;
  logic        s_wait   = 1'b0;
  logic        rdv_model = 1'b0, rdv_man = 1'b0;
  logic [31:0] model_data = '0, man_data = '0;

  assign s_if.waitrequest   = s_wait;
  assign s_if.readdatavalid = rdv_model | rdv_man;
  assign s_if.readdata      = rdv_man ? man_data : model_data;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (!sys_rst && model_en && s_if.read && !s_if.waitrequest)
      pend_q.push_back('{due: cyc + 3, addr: s_if.address});
  end

  always @(negedge sys_clk) begin
    rdv_model = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rdv_model  = 1'b1;
      model_data = mdata(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
  end

  // Monitor: acceptance order/timing and per-master read returns
  int          acc_q[$];
  int          acc_cyc[$];
  int          route_q[$];
  logic [31:0] rd0_q[$], rd1_q[$];

  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      if ((s_if.read || s_if.write) && !s_if.waitrequest) begin
        acc_q.push_back(m0_if.waitrequest ? 1 : 0);
        acc_cyc.push_back(cyc);
      end
      if (m0_if.readdatavalid) begin route_q.push_back(0); rd0_q.push_back(m0_if.readdata); end
      if (m1_if.readdatavalid) begin route_q.push_back(1); rd1_q.push_back(m1_if.readdata); end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_m(input int k, input logic rd, input logic wr, input logic [31:0] a);
    if (k == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.writedata = ~a; m0_if.byteenable = 4'hF;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.writedata = ~a; m1_if.byteenable = 4'hF;
    end
  endtask

  task automatic clr_q();
    acc_q.delete(); acc_cyc.delete(); route_q.delete(); rd0_q.delete(); rd1_q.delete();
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  // Present a command and hold it until accepted; returns on the negedge after acceptance.
  task automatic issue(input int k, input logic rd, input logic [31:0] a);
    logic w;
    set_m(k, rd, ~rd, a);
    for (int t = 0; t < 40; t++) begin
      #1;
      w = (k == 0) ? m0_if.waitrequest : m1_if.waitrequest;
      if (!w) begin @(negedge sys_clk); return; end
      @(negedge sys_clk);
    end
    chk("issue_timeout_waitrequest", w, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m;
    set_m(0, 0, 0, 0);
    set_m(1, 0, 0, 0);
    wait_cyc(3);
    #1;
    chk("rst_wait", {m0_if.waitrequest, m1_if.waitrequest, s_if.read, s_if.write, arb_err}, 5'b11000);
    sys_rst = 1'b0;
    wait_cyc(2);
    clr_q();

    // 1: m0-only streaming reads
    issue(0, 1, 32'h100);
    issue(0, 1, 32'h104);
    issue(0, 1, 32'h108);
    issue(0, 1, 32'h10C);
    set_m(0, 0, 0, 0);
    wait_cyc(8);
    chk("t1_nacc", acc_q.size(), 4);
    chk("t1_span", acc_cyc[3] - acc_cyc[0], 3);
    chk("t1_rdv0", rd0_q.size(), 4);
    chk("t1_rdv1", rd1_q.size(), 0);
    chk("t1_d0", rd0_q[0], 32'h5A5A_0E0F);
    chk("t1_d3", rd0_q[3], 32'h5A5A_0E03);

    // 2: both masters write continuously from reset; quantum alternation
    sys_rst = 1'b1;
    set_m(0, 0, 1, 32'h200);
    set_m(1, 0, 1, 32'h300);
    wait_cyc(2);
    clr_q();
    sys_rst = 1'b0;
    wait_cyc(70);
    set_m(0, 0, 0, 0);
    set_m(1, 0, 0, 0);
    wait_cyc(2);
    chk("t2_enough_acc", acc_q.size() >= 64, 1'b1);
    for (int b = 0; b < 4; b++) begin
      m = 0;
      for (int i = 0; i < 16; i++) if (acc_q[b*16+i] == (b % 2)) m++;
      chk($sformatf("t2_block%0d", b), m, 16);
    end
    chk("t2_nogap", acc_cyc[63] - acc_cyc[0], 63);

    // 3: stalled m1 write keeps its grant while m0 waits
    wait_cyc(2);
    clr_q();
    s_wait = 1'b1;
    set_m(1, 0, 1, 32'h400);
    @(negedge sys_clk);
    set_m(0, 1, 0, 32'h500);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t3_hold%0d", i),
          {m0_if.waitrequest, m1_if.waitrequest, s_if.write, s_if.read, s_if.address},
          {4'b1110, 32'h400});
      @(negedge sys_clk);
    end
    s_wait = 1'b0;
    #1;
    chk("t3_accept", {m1_if.waitrequest, s_if.write}, 2'b01);
    @(negedge sys_clk);
    set_m(1, 0, 0, 0);
    #1;
    chk("t3_still_g1", {m0_if.waitrequest, s_if.read, s_if.write}, 3'b100);
    @(negedge sys_clk);
    #1;
    chk("t3_g0", {m0_if.waitrequest, s_if.read, s_if.address}, {2'b01, 32'h500});
    @(negedge sys_clk);
    set_m(0, 0, 0, 0);
    wait_cyc(6);

    // 4: interleaved reads m0, m1, m0
    clr_q();
    issue(0, 1, 32'h1000);
    set_m(0, 0, 0, 0);
    issue(1, 1, 32'h2000);
    set_m(1, 0, 0, 0);
    issue(0, 1, 32'h3000);
    set_m(0, 0, 0, 0);
    wait_cyc(8);
    chk("t4_nroute", route_q.size(), 3);
    chk("t4_route", {route_q[0][0], route_q[1][0], route_q[2][0]}, 3'b010);
    chk("t4_d0a", rd0_q[0], 32'h5A5A_1F0F);
    chk("t4_d1", rd1_q[0], 32'h5A5A_2F0F);
    chk("t4_d0b", rd0_q[1], 32'h5A5A_3F0F);

    // 5: FIFO full stalls the 9th read; a pop releases it one cycle later
    clr_q();
    model_en = 1'b0;
    for (int i = 0; i < 8; i++) issue(0, 1, 32'h4000 + 32'(i*4));
    set_m(0, 1, 0, 32'h4100);
    #1;
    chk("t5_full_a", {m0_if.waitrequest, s_if.read}, 2'b10);
    @(negedge sys_clk);
    #1;
    chk("t5_full_b", {m0_if.waitrequest, s_if.read}, 2'b10);
    @(negedge sys_clk);
    man_data = 32'hCAFE_0001;
    rdv_man  = 1'b1;
    #1;
    chk("t5_pop_cycle", {m0_if.waitrequest, s_if.read, m0_if.readdatavalid, m1_if.readdatavalid}, 4'b1010);
    chk("t5_pop_data", m0_if.readdata, 32'hCAFE_0001);
    @(negedge sys_clk);
    rdv_man = 1'b0;
    #1;
    chk("t5_release", {m0_if.waitrequest, s_if.read}, 2'b01);
    @(negedge sys_clk);
    set_m(0, 0, 0, 0);
    chk("t5_nacc", acc_q.size(), 9);
    rdv_man = 1'b1;
    wait_cyc(8);
    rdv_man = 1'b0;
    #1;
    chk("t5_drain_rdv0", rd0_q.size(), 9);
    chk("t5_no_err", arb_err, 1'b0);

    // 6: spurious readdatavalid, then reset mid-burst
    @(negedge sys_clk);
    rdv_man = 1'b1;
    #1;
    chk("t6_dropped", {m0_if.readdatavalid, m1_if.readdatavalid}, 2'b00);
    @(negedge sys_clk);
    rdv_man = 1'b0;
    #1;
    chk("t6_err_set", arb_err, 1'b1);
    wait_cyc(3);
    chk("t6_err_sticky", arb_err, 1'b1);
    model_en = 1'b1;
    set_m(0, 0, 1, 32'h600);
    set_m(1, 0, 1, 32'h700);
    wait_cyc(5);
    sys_rst = 1'b1;
    #1;
    chk("t6_rst", {m0_if.waitrequest, m1_if.waitrequest, s_if.read, s_if.write, arb_err}, 5'b11000);
    wait_cyc(2);
    sys_rst = 1'b0;
    #1;
    chk("t6_idle", {m0_if.waitrequest, m1_if.waitrequest, s_if.write}, 3'b110);
    @(negedge sys_clk);
    #1;
    chk("t6_first_grant_m0", {m0_if.waitrequest, m1_if.waitrequest, s_if.write}, 3'b011);
    set_m(0, 0, 0, 0);
    set_m(1, 0, 0, 0);
    wait_cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
